// File: rtl/dt_estimator_mc_if.sv
// Sample/result bundle for the multi-channel dT estimator.
// The master side drives samples and configuration; the slave side (the estimator) returns results.
interface dt_estimator_mc_if #(
    parameter int W    = 8,
    parameter int N_CH = 4
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                 in_valid;
    logic [CW-1:0]        in_ch;
    logic signed [W-1:0]  T_in;
    logic                 in_init;
    logic                 init_all;
    logic [7:0]           alpha;
    logic [3:0]           k_dt;
    logic [W-1:0]         d_max;

    logic                 out_valid;
    logic [CW-1:0]        out_ch;
    logic signed [W-1:0]  dT_out;
    logic                 dt_valid;
    logic                 sat;

    modport master (
        output in_valid, in_ch, T_in, in_init, init_all, alpha, k_dt, d_max,
        input  out_valid, out_ch, dT_out, dt_valid, sat
    );

    modport slave (
        input  in_valid, in_ch, T_in, in_init, init_all, alpha, k_dt, d_max,
        output out_valid, out_ch, dT_out, dt_valid, sat
    );
endinterface

// File: rtl/dt_estimator_mc.sv
// Multi-channel dT estimator: per-channel EMA of sample-to-sample deltas with
// shift post-scaling and symmetric clamping. A single two-stage datapath is shared
// by all channels; stage 2 forwards its writeback to stage 1 when both work on the same channel.
module dt_estimator_mc #(
    parameter int W      = 8,
    parameter int N_CH   = 4,
    parameter int F      = 7,
    parameter int WARMUP = 4
) (
    input  logic              clk,
    input  logic              rst,
    dt_estimator_mc_if.slave  bus
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW = W + F + 1;
    localparam int PW = AW + 11;
    localparam int NW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [NW-1:0] WARM_V = NW'(WARMUP);
    localparam logic [W-1:0]  DCAP   = {1'b0, {(W-1){1'b1}}};

    // EMA mix: (acc*(256-alpha) + ds*alpha) >>> 8 with full-width products, floor shift
    function automatic logic signed [PW-1:0] ema_mix(input logic signed [AW-1:0] acc,
                                                     input logic signed [AW-1:0] ds,
                                                     input logic [7:0] a);
        logic signed [PW-1:0] acc_x, ds_x, w_old, w_new, sum;
        acc_x = {{(PW-AW){acc[AW-1]}}, acc};
        ds_x  = {{(PW-AW){ds[AW-1]}}, ds};
        w_old = {{(PW-9){1'b0}}, 9'd256 - {1'b0, a}};
        w_new = {{(PW-8){1'b0}}, a};
        sum   = acc_x * w_old + ds_x * w_new;
        return sum >>> 8;
    endfunction

    // Symmetric saturation to +/-(dlim << F); hit flags that the clamp engaged
    function automatic logic signed [AW-1:0] clamp_sym(input logic signed [PW-1:0] e,
                                                       input logic [W-1:0] dlim,
                                                       output logic hit);
        logic signed [PW-1:0] lim;
        lim = {{(PW-W){1'b0}}, dlim} <<< F;
        hit = 1'b0;
        if (e > lim) begin
            hit = 1'b1;
            return AW'(lim);
        end else if (e < -lim) begin
            hit = 1'b1;
            return AW'(-lim);
        end
        return AW'(e);
    endfunction

    // Drop the fractional bits (floor) and narrow to the output width; the clamp keeps it in range
    function automatic logic signed [W-1:0] to_out(input logic signed [AW-1:0] acc);
        return W'(acc >>> F);
    endfunction

    // Per-channel state
    logic signed [W-1:0]  tprev_mem [N_CH];
    logic signed [AW-1:0] acc_mem   [N_CH];
    logic [NW-1:0]        cnt_mem   [N_CH];
    logic [N_CH-1:0]      primed_mem;

    // Stage-1 registers
    logic                 vld_p1;
    logic                 prime_p1;
    logic [CW-1:0]        ch_p1;
    logic signed [W-1:0]  t_p1;
    logic signed [W-1:0]  tprev_p1;
    logic signed [AW-1:0] acc_p1;
    logic [NW-1:0]        cnt_p1;
    logic [7:0]           alpha_p1;
    logic [3:0]           kdt_p1;
    logic [W-1:0]         dlim_p1;

    // Stage-1 read side
    logic                 accept;
    logic                 fwd;
    logic                 rd_primed;
    logic signed [W-1:0]  rd_tprev;
    logic signed [AW-1:0] rd_acc;
    logic [NW-1:0]        rd_cnt;

    // Stage-2 compute
    logic                 wb;
    logic signed [W:0]    delta;
    logic signed [AW-1:0] ds_sh;
    logic signed [AW-1:0] ds;
    logic signed [PW-1:0] ema;
    logic signed [AW-1:0] clamped;
    logic                 hit;
    logic signed [W-1:0]  nxt_tprev;
    logic signed [AW-1:0] nxt_acc;
    logic [NW-1:0]        nxt_cnt;
    logic                 nxt_sat;
    logic                 nxt_dtv;

    // Accept qualification and state read, with bypass of the writeback happening this cycle
    always_comb begin
        accept    = bus.in_valid && !bus.init_all && (int'(bus.in_ch) < N_CH);
        fwd       = vld_p1 && (ch_p1 == bus.in_ch);
        rd_primed = primed_mem[bus.in_ch];
        rd_tprev  = tprev_mem[bus.in_ch];
        rd_acc    = acc_mem[bus.in_ch];
        rd_cnt    = cnt_mem[bus.in_ch];
        if (fwd) begin
            rd_primed = 1'b1;
            rd_tprev  = nxt_tprev;
            rd_acc    = nxt_acc;
            rd_cnt    = nxt_cnt;
        end
    end

    // ---- stage 1: sample, channel, config and state captured ----

    // Stage-1 valid; init_all and out-of-range channels never enter the pipe
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= accept;
    end

    // Stage-1 data capture; qualified by vld_p1 so no reset needed
    always_ff @(posedge clk) begin
        prime_p1 <= bus.in_init || !rd_primed;
        ch_p1    <= bus.in_ch;
        t_p1     <= bus.T_in;
        tprev_p1 <= rd_tprev;
        acc_p1   <= rd_acc;
        cnt_p1   <= rd_cnt;
        alpha_p1 <= bus.alpha;
        kdt_p1   <= bus.k_dt;
        dlim_p1  <= (bus.d_max > DCAP) ? DCAP : bus.d_max;
    end

    // EMA update, clamp and warm-up count for the stage-1 sample
    always_comb begin
        hit       = 1'b0;
        wb        = vld_p1 && !bus.init_all;
        delta     = {t_p1[W-1], t_p1} - {tprev_p1[W-1], tprev_p1};
        ds_sh     = {delta, {F{1'b0}}};
        ds        = ds_sh >>> kdt_p1;
        ema       = ema_mix(acc_p1, ds, alpha_p1);
        clamped   = clamp_sym(ema, dlim_p1, hit);
        nxt_tprev = t_p1;
        if (prime_p1) begin
            nxt_acc = '0;
            nxt_cnt = '0;
            nxt_sat = 1'b0;
            nxt_dtv = 1'b0;
        end else begin
            nxt_acc = clamped;
            nxt_cnt = (cnt_p1 >= WARM_V) ? WARM_V : cnt_p1 + NW'(1);
            nxt_sat = hit;
            nxt_dtv = (nxt_cnt >= WARM_V);
        end
    end

    // ---- stage 2: state writeback and registered outputs ----

    // Channel state writeback; init_all wipes history but keeps T_prev, rst clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            primed_mem <= '0;
            for (int i = 0; i < N_CH; i++) begin
                tprev_mem[i] <= '0;
                acc_mem[i]   <= '0;
                cnt_mem[i]   <= '0;
            end
        end else if (bus.init_all) begin
            primed_mem <= '0;
            for (int i = 0; i < N_CH; i++) begin
                acc_mem[i] <= '0;
                cnt_mem[i] <= '0;
            end
        end else if (vld_p1) begin
            primed_mem[ch_p1] <= 1'b1;
            tprev_mem[ch_p1]  <= nxt_tprev;
            acc_mem[ch_p1]    <= nxt_acc;
            cnt_mem[ch_p1]    <= nxt_cnt;
        end
    end

    // Result registers; data fields hold between results
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.dT_out    <= '0;
            bus.dt_valid  <= 1'b0;
            bus.sat       <= 1'b0;
        end else begin
            bus.out_valid <= wb;
            if (wb) begin
                bus.out_ch   <= ch_p1;
                bus.dT_out   <= to_out(nxt_acc);
                bus.dt_valid <= nxt_dtv;
                bus.sat      <= nxt_sat;
            end
        end
    end
endmodule

// File: doc/dt_estimator_mc.md
# dt_estimator_mc

Multi-channel, parametrised successor of the single-channel dT estimator. It computes a per-channel exponential moving average (EMA) of sample-to-sample temperature deltas, with shift scaling and symmetric saturation. One shared two-stage datapath is time-multiplexed over N_CH channels, with per-channel state held in register arrays. It sits between the multiplexed sensor front end and the control core, and is used when DT_MODE=1.

## Interface
- W, 8: signed sample width of T_in/dT_out (integer format QW.0)
- N_CH, 4: number of channels; localparam CW = max(1, $clog2(N_CH))
- F, 7: fractional bits of the internal accumulator; accumulator width AW = W+F+1, signed
- WARMUP, 4: accepted non-priming samples needed before dt_valid rises
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample strobe; no backpressure, one sample may be accepted every cycle
- in_ch  in  CW  channel index of the sample
- T_in  in  W  signed sample
- in_init  in  1  re-prime the addressed channel with this sample
- init_all  in  1  clear all channels and flush the pipeline
- alpha  in  8  EMA weight alpha/256, range 0..255
- k_dt  in  4  post-scale by 2^-k_dt
- d_max  in  W  unsigned clamp; effective clamp = min(d_max, 2^(W-1)-1)
- out_valid  out  1  result strobe
- out_ch  out  CW  channel of the result
- dT_out  out  W  signed filtered delta
- dt_valid  out  1  channel warm-up complete, qualified by out_valid
- sat  out  1  clamp engaged on this result

## Operation
- Per-channel state:
  - T_prev[W]
  - acc[AW]
  - primed bit
  - cnt, saturating at WARMUP
- A sample is accepted when in_valid=1, in_ch<N_CH, and init_all=0. Accepting a sample with in_ch≥N_CH is not allowed: the sample is dropped and produces no output.
- Priming path (taken when the channel is not primed or in_init=1):
  - T_prev←T_in, acc←0, cnt←0, primed←1.
  - Output dT_out=0, dt_valid=0, sat=0. No output spike on init.
- Update path (all other accepted samples):
  - delta = T_in − T_prev, computed at W+1 bits signed.
  - ds = (delta <<< F) >>> k_dt, arithmetic shift. The result is 0 or −1 when k_dt ≥ AW.
  - e = (acc·(256−alpha) + ds·alpha) >>> 8. Products are full width; the shift is arithmetic (floor).
  - Clamp: if e > D, acc←D and sat=1; if e < −D, acc←−D and sat=1; otherwise acc←e. Here D = effective d_max <<< F.
  - dT_out = acc_new >>> F, floored, then truncated to W bits. The clamp guarantees the value fits in W bits.
  - T_prev←T_in.
  - cnt←min(cnt+1, WARMUP); dt_valid = (cnt_new ≥ WARMUP).
- alpha, k_dt and d_max are sampled in the same cycle as the sample and are shared by all channels.
- init_all, whether or not in_valid is set:
  - All primed←0, acc←0, cnt←0.
  - In-flight stage-1 work is discarded, so no out_valid in the next 2 cycles from earlier samples.
  - A sample in the same cycle is ignored.
- rst has the same effect as init_all, and additionally clears T_prev to 0.

## Timing
- Output reset values: out_valid=0, out_ch=0, dT_out=0, dt_valid=0, sat=0.
- Stage 1 (edge k+1): register the sample, the channel, the config, the state read and the path select.
- Stage 2 (edge k+2): compute the EMA and clamp, write back the channel state, and register the outputs.
- Fixed latency 2: a sample accepted in cycle k gives out_valid=1 in cycle k+2 for exactly one cycle. Order is preserved.
- Hazard: when a stage-1 sample has the same channel as the stage-2 writeback in the same cycle, stage 1 must use the forwarded new state (T_prev, acc, primed, cnt). Back-to-back and interleaved samples on the same channel must match a serial model exactly.
- An init on channel c does not disturb other channels or samples already in flight on other channels.
- Reset or init_all during a stream: the next accepted sample on every channel takes the priming path.

## Test plan
- Priming and update, with W=8, F=7, alpha=128, k_dt=0, d_max=127:
  - ch0 T=0 → dT_out=0, dt_valid=0.
  - ch0 T=10 → acc 640, dT=5.
  - ch0 T=20 → acc 960, dT=7. Each out_valid occurs 2 cycles after its input.
- Negative and floor: alpha=255, ch1 T=0 then T=−10 → acc −1275, dT_out=−10, sat=0.
- Clamp: d_max=3, alpha=255, ch2 T=0 then T=100 → dT_out=3, sat=1, acc held at 384. Next T=−100 → dT_out=−3, sat=1.
- Forwarding: alternate back-to-back ch3 and ch0 every cycle, including consecutive same-channel samples (ch3 T=0,10,20 on cycles k..k+2) → outputs equal the serial-model values above. No stale state is used.
- Warm-up and init: ch0 gets 1 priming sample plus 4 updates → dt_valid=0,0,0,0,1. in_init on sample 6 → dT_out=0, dt_valid=0, with no spike on the following sample when T is unchanged.
- init_all mid-stream and rst: samples in flight produce no out_valid. The next ch0 sample primes (dT_out=0). in_ch=N_CH produces no output. All outputs are 0 after rst.
